// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the ALU sequencer and its ROM / ALU / debug environment.
interface alu_op_sequencer_if;
  logic       START;
  logic [7:0] INSTR;
  logic [3:0] PC;
  logic [3:0] ALU_A;
  logic [3:0] ALU_B;
  logic       ALU_M;
  logic       ALU_S1;
  logic       ALU_S0;
  logic [3:0] ALU_F;
  logic       ALU_COUT;
  logic       CARRY;
  logic       BUSY;
  logic       HALTED;
  logic [1:0] DBG_SEL;
  logic [3:0] DBG_REG;

  modport master (
    input  START, INSTR, ALU_F, ALU_COUT, DBG_SEL,
    output PC, ALU_A, ALU_B, ALU_M, ALU_S1, ALU_S0, CARRY, BUSY, HALTED, DBG_REG
  );

  modport slave (
    output START, INSTR, ALU_F, ALU_COUT, DBG_SEL,
    input  PC, ALU_A, ALU_B, ALU_M, ALU_S1, ALU_S0, CARRY, BUSY, HALTED, DBG_REG
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/writeback sequencer driving an external 4-bit ALU from a
// 4x4 register file, executing 8-bit instructions from a combinational ROM.
module alu_op_sequencer (
  input logic               CLK,
  input logic               RST_N,
  alu_op_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HALTED
  } state_t;

  state_t     state, state_nx;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] regs [4];
  logic       carry;

  logic       is_alu, is_ldi, is_halt;
  logic [1:0] rd, rb;
  logic       pc_clr, pc_inc, ir_ld, wb_en;

  // Decode is purely from IR, so operands hold steady across EXEC and WB.
  always_comb begin
    is_alu  = ~ir[7];
    is_ldi  = (ir[7:6] == 2'b10);
    is_halt = (ir[7:6] == 2'b11);
    rd      = is_alu ? ir[3:2] : ir[5:4];
    rb      = ir[1:0];
  end

  always_comb begin
    bus.ALU_A = regs[rd];
    bus.ALU_B = regs[rb];
    if (is_alu) {bus.ALU_M, bus.ALU_S1, bus.ALU_S0} = ir[6:4];
    else        {bus.ALU_M, bus.ALU_S1, bus.ALU_S0} = '0;
    bus.PC      = pc;
    bus.CARRY   = carry;
    bus.BUSY    = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_WB);
    bus.HALTED  = (state == ST_HALTED);
    bus.DBG_REG = regs[bus.DBG_SEL];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    wb_en    = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (bus.START) begin
          state_nx = ST_FETCH;
          pc_clr   = 1'b1;
        end
      end
      ST_FETCH: begin
        ir_ld    = 1'b1;
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        state_nx = is_halt ? ST_HALTED : ST_WB;
      end
      ST_WB: begin
        wb_en    = 1'b1;
        pc_inc   = 1'b1;
        state_nx = ST_FETCH;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc    <= '0;
      ir    <= '0;
      carry <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (pc_clr)      pc <= '0;
      else if (pc_inc) pc <= pc + 4'd1;
      if (ir_ld) ir <= bus.INSTR;
      if (wb_en) begin
        if (is_alu) begin
          regs[rd] <= bus.ALU_F;
          carry    <= bus.ALU_COUT;
        end else if (is_ldi) begin
          regs[rd] <= ir[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: ROM and ALU modelled here, expected
// per-instruction results queued from a reference model and checked in order.
module tb_alu_op_sequencer;

  typedef struct {
    logic [1:0] kind;   // 0 = ALU op, 1 = LDI, 2 = HALT
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [1:0] rd;
    logic [3:0] val;
    logic       carry;
    logic [3:0] pc;
  } exp_t;

  logic CLK;
  logic RST_N;
  alu_op_sequencer_if bus();

  logic [7:0] rom [16];
  logic [3:0] mreg [4];
  logic       mcarry;
  exp_t       sbq[$];
  int         total;
  int         passed;
  int         failed;

  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    logic [3:0] f;
    f = a + b + (sel[1] ? 4'd2 : 4'd0) + (sel[2] ? 4'd0 : 4'd1);
    return {^{a, b, sel}, f};
  endfunction

  assign bus.INSTR = rom[bus.PC];
  assign {bus.ALU_COUT, bus.ALU_F} =
    alu_model(bus.ALU_A, bus.ALU_B, {bus.ALU_M, bus.ALU_S1, bus.ALU_S0});

  alu_op_sequencer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    mcarry = 1'b0;
  endtask

  // Walk the ROM through the reference model, queueing one entry per instruction.
  task automatic build(input int max_steps);
    logic [3:0] pc;
    logic [7:0] ins;
    logic [4:0] r;
    exp_t       e;
    pc = '0;
    for (int s = 0; s < max_steps; s++) begin
      ins   = rom[pc];
      e.pc  = pc;
      e.a   = '0;
      e.b   = '0;
      e.sel = '0;
      e.rd  = '0;
      if (!ins[7]) begin
        e.kind = 2'd0;
        e.sel  = ins[6:4];
        e.rd   = ins[3:2];
        e.a    = mreg[ins[3:2]];
        e.b    = mreg[ins[1:0]];
        r      = alu_model(e.a, e.b, e.sel);
        mreg[e.rd] = r[3:0];
        mcarry     = r[4];
      end else if (!ins[6]) begin
        e.kind = 2'd1;
        e.rd   = ins[5:4];
        mreg[e.rd] = ins[3:0];
      end else begin
        e.kind = 2'd2;
      end
      e.val   = mreg[e.rd];
      e.carry = mcarry;
      sbq.push_back(e);
      if (e.kind == 2'd2) break;
      pc = pc + 4'd1;
    end
  endtask

  // Called at a negedge with the DUT idle/halted; consumes the whole queue.
  task automatic run(input int pulse_idx);
    exp_t e;
    int   idx;
    idx = 0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("fetch_pc", 8'(bus.PC), 8'(e.pc));
      chk("fetch_busy", 8'(bus.BUSY), 8'd1);
      @(negedge CLK);
      if (idx == pulse_idx) bus.START = 1'b1;
      chk("exec_sel", 8'({bus.ALU_M, bus.ALU_S1, bus.ALU_S0}), 8'(e.sel));
      if (e.kind == 2'd0) begin
        chk("exec_a", 8'(bus.ALU_A), 8'(e.a));
        chk("exec_b", 8'(bus.ALU_B), 8'(e.b));
      end
      if (e.kind == 2'd2) begin
        chk("exec_halted", 8'(bus.HALTED), 8'd0);
        @(negedge CLK);
        chk("halted", 8'(bus.HALTED), 8'd1);
        chk("halted_busy", 8'(bus.BUSY), 8'd0);
        chk("halted_pc", 8'(bus.PC), 8'(e.pc));
      end else begin
        @(negedge CLK);
        bus.START = 1'b0;
        if (e.kind == 2'd0) begin
          chk("wb_a", 8'(bus.ALU_A), 8'(e.a));
          chk("wb_b", 8'(bus.ALU_B), 8'(e.b));
        end
        @(negedge CLK);
        bus.DBG_SEL = e.rd;
        #1;
        chk("wb_reg", 8'(bus.DBG_REG), 8'(e.val));
        chk("wb_carry", 8'(bus.CARRY), 8'(e.carry));
      end
      idx++;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pc"}, 8'(bus.PC), 8'd0);
    chk({tag, "_a"}, 8'(bus.ALU_A), 8'd0);
    chk({tag, "_b"}, 8'(bus.ALU_B), 8'd0);
    chk({tag, "_sel"}, 8'({bus.ALU_M, bus.ALU_S1, bus.ALU_S0}), 8'd0);
    chk({tag, "_busy"}, 8'(bus.BUSY), 8'd0);
    chk({tag, "_halted"}, 8'(bus.HALTED), 8'd0);
    chk({tag, "_carry"}, 8'(bus.CARRY), 8'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    RST_N  = 1'b0;
    bus.START   = 1'b0;
    bus.DBG_SEL = 2'd0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    model_reset();

    // Reset state
    #12;
    check_zero_outputs("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset asserted mid-EXEC of 0x51 aborts without a write
    rom[0] = 8'h85; rom[1] = 8'h94; rom[2] = 8'h51; rom[3] = 8'hC0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (7) @(negedge CLK);
    chk("pre_rst_a", 8'(bus.ALU_A), 8'd5);
    chk("pre_rst_sel", 8'({bus.ALU_M, bus.ALU_S1, bus.ALU_S0}), 8'd5);
    RST_N = 1'b0;
    #1;
    check_zero_outputs("midrst");
    for (int i = 0; i < 4; i++) begin
      bus.DBG_SEL = 2'(i);
      #1;
      chk("midrst_reg", 8'(bus.DBG_REG), 8'd0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_busy", 8'(bus.BUSY), 8'd0);
    chk("idle_pc", 8'(bus.PC), 8'd0);

    // LDI program
    for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    rom[0] = 8'h85; rom[1] = 8'h94;
    build(20);
    run(-1);

    // ALU op program (restart from HALTED)
    rom[2] = 8'h51;
    build(20);
    run(-1);
    chk("alu_r0", 8'(mreg[0]), 8'd9);
    chk("alu_carry_model", 8'(mcarry), 8'd1);

    // Select sweep 000..111, accumulating into R0
    for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    rom[0] = 8'h85; rom[1] = 8'h94;
    for (int i = 0; i < 8; i++) rom[2 + i] = {1'b0, 3'(i), 4'b0001};
    build(20);
    run(-1);

    // Restart: immediate HALT, registers and carry retained
    for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    build(20);
    run(-1);
    for (int i = 0; i < 4; i++) begin
      bus.DBG_SEL = 2'(i);
      #1;
      chk("retain_reg", 8'(bus.DBG_REG), 8'(mreg[i]));
    end
    chk("retain_carry", 8'(bus.CARRY), 8'(mcarry));

    // PC wrap with a START pulse mid-run
    for (int i = 0; i < 16; i++) rom[i] = {2'b10, 2'(i % 4), 4'(15 - i)};
    build(18);
    run(5);
    chk("wrap_busy", 8'(bus.BUSY), 8'd1);
    chk("wrap_pc", 8'(bus.PC), 8'd2);

    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("final_pc", 8'(bus.PC), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control-and-register stage feeding the 4-bit ALU in the toy processor. It fetches 8-bit instructions from an external combinational program ROM and decodes them. It drives the ALU operands and function selects (M, S1, S0) from a 4-entry × 4-bit register file, then writes the ALU result and carry back. It turns the ALU from a hand-driven block into one that executes a short program.

## Interface
Parameters: none (widths fixed: 4-bit data, 4-bit PC, 4 registers).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  level; sampled only in IDLE/HALTED; begins execution at PC=0.
- INSTR  in  8  program ROM data for address PC; valid same cycle.
- PC  out  4  program counter / ROM address.
- ALU_A  out  4  operand A = R[rd].
- ALU_B  out  4  operand B = R[rb].
- ALU_M, ALU_S1, ALU_S0  out  1 each  ALU function select.
- ALU_F  in  4  ALU result (F3..F0).
- ALU_COUT  in  1  ALU carry out (CiOut).
- CARRY  out  1  carry flag.
- BUSY  out  1  high in FETCH/EXEC/WB.
- HALTED  out  1  high in HALTED state.
- DBG_SEL  in  2  register select for debug read.
- DBG_REG  out  4  R[DBG_SEL], combinational.

## Operation
Instruction encoding, captured into internal 8-bit IR:
- IR[7]=0, ALU op: {M,S1,S0}=IR[6:4], rd=IR[3:2], rb=IR[1:0]; R[rd] <= ALU_F; CARRY <= ALU_COUT.
- IR[7:6]=10, LDI: rd=IR[5:4], R[rd] <= IR[3:0]; CARRY unchanged.
- IR[7:6]=11, HALT: remaining bits ignored.

ALU drive:
- ALU_A, ALU_B, ALU_M, ALU_S1, ALU_S0 decode combinationally from IR and the register file.
- For non-ALU IR values, ALU_M/S1/S0 are forced to 0.

FSM:
- IDLE: START=1 -> FETCH; PC<=0.
- FETCH: IR<=INSTR -> EXEC.
- EXEC: ALU inputs settle; IR=HALT -> HALTED, PC not incremented; otherwise -> WB.
- WB: register/CARRY write per encoding; PC<=PC+1, 4-bit wrap 15->0; -> FETCH.
- HALTED: START=1 -> FETCH; PC<=0. Registers and CARRY are retained.

Boundary rules:
- START is ignored while BUSY.
- A write to rd=rb uses the pre-write value as ALU_B (operands are stable through WB).
- PC wrap continues execution at address 0; there is no implicit halt.

## Timing
- Reset (async assert, any state): state=IDLE, PC=0, IR=0, R0..R3=0, CARRY=0.
- Reset output values: ALU_A=0, ALU_B=0, ALU_M/S1/S0=0, BUSY=0, HALTED=0.
- Reset deassertion is synchronous to CLK; the first START sampled is on the following edge.
- Reset mid-instruction aborts with no partial write.
- Every ALU/LDI instruction takes 3 cycles (FETCH, EXEC, WB).
- ALU inputs are stable for 2 full cycles (EXEC+WB) before capture, which allows combinational ALU settle time.
- The register write is visible on DBG_REG the cycle after WB.
- HALT takes 2 cycles (FETCH, EXEC); HALTED asserts the cycle after EXEC.
- BUSY rises on the edge leaving IDLE/HALTED and falls entering HALTED.

## Test plan
- Reset: assert RST_N=0 mid-EXEC -> all outputs 0 immediately; after release with START=0, state stays IDLE, PC=0.
- LDI: ROM {0x85 (LDI R0,5), 0x94 (LDI R1,4), 0xC0} -> R0=5, R1=4, CARRY=0; HALTED after 8 cycles from START; PC=2.
- ALU op: ROM {0x85, 0x94, 0x51 (M,S1,S0=101, rd=0, rb=1), 0xC0} -> during EXEC of 0x51: ALU_A=5, ALU_B=4, M=1, S1=0, S0=1. Bench ALU returns F=9, COUT=1 -> R0=9, CARRY=1.
- Select sweep: eight ALU ops 0x01..0x71 -> {M,S1,S0} on outputs equals 000..111 in order. Each result is written to R0 with carry tracking COUT per step.
- PC wrap / START ignore: 16 LDI instructions, no HALT -> PC goes 15->0 and execution continues. A START pulse mid-run changes nothing.
- Restart: in HALTED, START=1 -> PC=0 and R0..R3/CARRY retained until overwritten.
